extender: RTL and testbench

//  16->32-bit immediate extender for the MIPS pipeline decode stage.

---
 rtl/extender.sv | 81 ++++++++
 tb/tb_extender.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/extender.sv
// extender: IMM_W -> OUT_W immediate extender for the decode stage.
// Zero- or sign-extends the immediate according to ExtendType and registers
// the result with a valid flag (1-cycle latency, no back-pressure).
// Optional feature macro: EXT_LUI_EN adds the ShiftUpper input, which places
// the immediate in the upper bits of the result (LUI) and ignores ExtendType.
// IMM_W must be smaller than OUT_W.
module extender #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IMM_W-1:0] Immediate,
    input  logic             ExtendType,
    input  logic             InValid,
`ifdef EXT_LUI_EN
    input  logic             ShiftUpper,
`endif
    output logic [OUT_W-1:0] Result,
    output logic             OutValid
);

    localparam int PAD_W = OUT_W - IMM_W;

    // Single shared extension function: upper placement wins over the
    // zero/sign selection, so ExtendType is a don't-care for LUI.
    function automatic logic [OUT_W-1:0] ext(
        input logic [IMM_W-1:0] imm,
        input logic             sign_en,
        input logic             upper
    );
        logic [OUT_W-1:0] r;
        if (upper) begin
            r = {imm, {PAD_W{1'b0}}};
        end else if (sign_en) begin
            r = {{PAD_W{imm[IMM_W-1]}}, imm};
        end else begin
            r = {{PAD_W{1'b0}}, imm};
        end
        return r;
    endfunction

    logic             shift_upper;
    logic [OUT_W-1:0] next_result;

`ifdef EXT_LUI_EN
    assign shift_upper = ShiftUpper;
`else
    assign shift_upper = 1'b0;
`endif

    // Combinational extension of the current immediate.
    always_comb begin
        // NOTE: assign a default first in always_comb so no path leaves the
        // signal unassigned, which would infer a latch.
        next_result = '0;
        next_result = ext(Immediate, ExtendType, shift_upper);
    end

    // Output register: capture on a valid input, otherwise hold the data and
    // drop the valid flag; reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            Result   <= '0;
            OutValid <= 1'b0;
        end else begin
            OutValid <= InValid;
            if (InValid) begin
                Result <= next_result;
            end
        end
    end

    // An unknown ExtendType on a valid input is illegal.
    a_ext_type_known: assert property (
        @(posedge clk) disable iff (reset) InValid |-> !$isunknown(ExtendType)
    );

endmodule

// File: tb/tb_extender.sv
// Self-checking bench for extender: table-driven vectors plus hand-written
// sequences for reset, hold and mid-stream reset; expected results go
// through a scoreboard queue and are compared one cycle after driving.
module tb_extender;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] Immediate;
    logic        ExtendType;
    logic        InValid;
    logic        ShiftUpper;
    logic [31:0] Result;
    logic        OutValid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] result;
        logic        valid;
        string       name;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [15:0] imm;
        logic        et;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[8];

    extender #(.IMM_W(16), .OUT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Immediate  (Immediate),
        .ExtendType (ExtendType),
        .InValid    (InValid),
`ifdef EXT_LUI_EN
        .ShiftUpper (ShiftUpper),
`endif
        .Result     (Result),
        .OutValid   (OutValid)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference extension written independently of the DUT.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic et);
        logic [31:0] r;
        r = {16'h0000, imm};
        if (et && imm[15]) r[31:16] = 16'hFFFF;
        return r;
    endfunction

    // Drive one cycle of stimulus at the negedge, push the expectation,
    // then pop and compare just after the next posedge.
    task automatic drive(input logic r, input logic [15:0] imm, input logic et,
                         input logic v, input logic su,
                         input logic [31:0] exp_res, input logic exp_val,
                         input string name);
        exp_t e;
        reset      = r;
        Immediate  = imm;
        ExtendType = et;
        InValid    = v;
        ShiftUpper = su;
        sb.push_back('{exp_res, exp_val, name});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, Result, e.result);
            check({e.name, "_valid"}, {31'd0, OutValid}, {31'd0, e.valid});
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] imm;
        logic        et;

        vecs[0] = '{16'h8000, 1'b1, 32'hFFFF8000, "b8000_sign"};
        vecs[1] = '{16'h8000, 1'b0, 32'h00008000, "b8000_zero"};
        vecs[2] = '{16'h7FFF, 1'b1, 32'h00007FFF, "b7fff_sign"};
        vecs[3] = '{16'h7FFF, 1'b0, 32'h00007FFF, "b7fff_zero"};
        vecs[4] = '{16'h0000, 1'b1, 32'h00000000, "b0000_sign"};
        vecs[5] = '{16'h0000, 1'b0, 32'h00000000, "b0000_zero"};
        vecs[6] = '{16'hFFFF, 1'b0, 32'h0000FFFF, "bffff_zero"};
        vecs[7] = '{16'h1234, 1'b0, 32'h00001234, "b1234_zero"};

        reset      = 1'b1;
        Immediate  = 16'h0000;
        ExtendType = 1'b0;
        InValid    = 1'b0;
        ShiftUpper = 1'b0;
        @(negedge clk);

        // Reset held for two cycles wins over a valid input.
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, "reset0");
        drive(1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, "reset1");

        // First valid transaction after reset.
        drive(1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, "first");

        // Back-to-back walk: Immediate += 0xFFFF, ExtendType toggling.
        imm = 16'hFFFF;
        et  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            imm = imm + 16'hFFFF;
            et  = ~et;
            drive(1'b0, imm, et, 1'b1, 1'b0, ref_ext(imm, et), 1'b1,
                  $sformatf("walk%0d", i));
        end

        // Spot checks of the walk's first two results against literals.
        drive(1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0, 32'h0000FFFE, 1'b1, "walk_lit0");
        drive(1'b0, 16'hFFFD, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFD, 1'b1, "walk_lit1");

        // Boundary table; ends on 0x1234/zero for the hold sequence.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, vecs[i].imm, vecs[i].et, 1'b1, 1'b0,
                  vecs[i].exp, 1'b1, vecs[i].name);
        end

        // InValid drops: data holds, valid clears, inputs ignored.
        drive(1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 32'h00001234, 1'b0, "hold0");
        drive(1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 32'h00001234, 1'b0, "hold1");

        // Valid again, then reset mid-stream clears on the next edge.
        drive(1'b0, 16'h8001, 1'b1, 1'b1, 1'b0, 32'hFFFF8001, 1'b1, "pre_rst");
        drive(1'b1, 16'h5555, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b0, "mid_rst");
        drive(1'b0, 16'h5555, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b0, "post_rst");
        drive(1'b0, 16'h5555, 1'b0, 1'b1, 1'b0, 32'h00005555, 1'b1, "resume");

`ifdef EXT_LUI_EN
        // LUI placement ignores ExtendType; clearing ShiftUpper restores extension.
        drive(1'b0, 16'hABCD, 1'b1, 1'b1, 1'b1, 32'hABCD0000, 1'b1, "lui_sign");
        drive(1'b0, 16'hABCD, 1'b0, 1'b1, 1'b1, 32'hABCD0000, 1'b1, "lui_zero");
        drive(1'b0, 16'hABCD, 1'b1, 1'b1, 1'b0, 32'hFFFFABCD, 1'b1, "lui_off");
`endif

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
